forward_hazard_unit: RTL and testbench
======================================

FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

Interface
REQ-001 SHALL have parameter REG_AW, default 5: register address width.
REQ-002 SHALL have parameter NUM_SRC, default 2: EX source operands checked.
REQ-003 SHALL have parameter NUM_STG, default 2: forwarding stages after EX; index 0 is nearest (MEM), NUM_STG-1 is farthest (WB).
REQ-004 SHALL have parameter LOAD_LAT, default 1: load-use stall cycles, range 1..15.
REQ-005 SHALL have parameter CNT_W, default 16: statistics counter width.
REQ-006 SHALL have derived localparam SEL_W = clog2(NUM_STG+1).
REQ-007 SHALL have the following ports:
- clk_i  in  1  sole clock; all state on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- ex_src_i  in  NUM_SRC*REG_AW  EX source addresses; slice j = operand j.
- id_src_i  in  NUM_SRC*REG_AW  ID source addresses.
- id_src_use_i  in  NUM_SRC  ID operand j is actually read.
- stg_rd_i  in  NUM_STG*REG_AW  destination address per downstream stage.
- stg_we_i  in  NUM_STG  RegWrite per downstream stage.
- ex_rd_i  in  REG_AW  destination of the instruction in EX.
- ex_memread_i  in  1  instruction in EX is a load.
- clr_cnt_i  in  1  synchronous clear of statistics.
- fwd_sel_o  out  NUM_SRC*SEL_W  per operand: 0 = register file, k = stage k-1.
- stall_o  out  1  hold PC and IF/ID.
- bubble_o  out  1  zero ID/EX control.
- stall_cnt_o  out  CNT_W  cycles with stall_o high.
- fwd_cnt_o  out  CNT_W  cycles with any fwd_sel_o nonzero.

Function
REQ-008 SHALL set operand j select to k+1 for the lowest stage k with stg_we_i[k]=1, stg_rd_i[k]!=0 and stg_rd_i[k]==ex_src_i[j]; otherwise 0.
- Nearest stage wins.
- Register 0 is never forwarded.
- fwd_sel_o is combinational, zero latency.
REQ-009 SHALL detect load-use when all hold:
- ex_memread_i=1;
- ex_rd_i!=0;
- for some j: id_src_use_i[j]=1 and id_src_i[j]==ex_rd_i.
REQ-010 SHALL implement FSM states IDLE and STALL plus a 4-bit down-counter rem.
REQ-011 In IDLE with load-use: stall_o=1 and bubble_o=1 that same cycle (Mealy).
- If LOAD_LAT>1: next state STALL, rem=LOAD_LAT-2.
- If LOAD_LAT=1: stay IDLE.
REQ-012 In STALL: stall_o=1 and bubble_o=1 regardless of inputs; load-use detection is ignored.
- rem decrements each cycle.
- rem=0 returns the FSM to IDLE on the next edge.
REQ-013 In IDLE without load-use: stall_o=0 and bubble_o=0.
REQ-014 Forwarding SHALL remain active during stalls; fwd_sel_o is independent of FSM state.
REQ-015 stall_cnt_o SHALL increment by 1 on each edge where stall_o=1.
REQ-016 fwd_cnt_o SHALL increment by 1 on each edge where any fwd_sel_o slice is nonzero.
REQ-017 Both counters SHALL saturate at all-ones and never wrap.
REQ-018 clr_cnt_i=1 SHALL zero both counters on the next edge, taking priority over a simultaneous increment.

Reset
REQ-019 rst_i=1 SHALL immediately, asynchronously:
- force FSM to IDLE and rem to 0;
- zero both counters;
- force stall_o=0, bubble_o=0 and fwd_sel_o=0 while asserted, irrespective of other inputs.
REQ-020 Reset asserted mid-STALL SHALL abandon the stall; after deassertion the FSM starts in IDLE.

Structure
REQ-021 A shared package hazard_pkg SHALL hold:
- FSM state encoding (IDLE=0, STALL=1);
- select constant FWD_NONE=0.
REQ-022 The per-operand priority match SHALL be a sub-module fwd_src_match, instantiated NUM_SRC times by generate.

Verification
REQ-023 Defaults; stg_we=2'b11, stg_rd={5,5}, ex_src0=5 -> fwd_sel0=1 (stage 0 wins).
REQ-024 ex_src1=0, stg_rd0=0, stg_we0=1 -> fwd_sel1=0; fwd_cnt_o unchanged.
REQ-025 LOAD_LAT=3; ex_memread=1, ex_rd=8, id_src0=8, id_src_use0=1 -> stall_o and bubble_o high exactly 3 consecutive cycles; stall_cnt_o +3.
REQ-026 LOAD_LAT=3; rst_i pulsed during the second stall cycle -> stall_o=0 immediately; FSM in IDLE; counters 0.
REQ-027 CNT_W=4; forwarding held 20 cycles -> fwd_cnt_o saturates at 15.
REQ-028 CNT_W=4; clr_cnt_i=1 while incrementing -> fwd_cnt_o=0 next cycle.
REQ-029 NUM_STG=3, NUM_SRC=3; match only in stage 2 for operand 2 -> fwd_sel2=3; other operands 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the forwarding / load-use hazard unit.
package hazard_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } hazState_t;

  // Select value meaning "take the operand from the register file".
  localparam int unsigned FWD_NONE = 0;

  // Width of the remaining-stall-cycles down-counter.
  localparam int unsigned REM_W = 4;

endpackage

// File: rtl/fwd_src_match.sv
// Priority match of one EX source operand against the downstream
// destination registers. The nearest stage (lowest index) wins, and
// register 0 is never forwarded.
module fwd_src_match
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned NUM_STG = 2,
  parameter int unsigned SEL_W   = $clog2(NUM_STG + 1)
) (
  input  logic [REG_AW-1:0]         src,
  input  logic [NUM_STG*REG_AW-1:0] stgRd,
  input  logic [NUM_STG-1:0]        stgWe,
  output logic [SEL_W-1:0]          sel
);

  logic hit;

  // Scan from nearest to farthest; first qualifying stage is latched by hit.
  always_comb begin
    sel = SEL_W'(FWD_NONE);
    hit = 1'b0;
    for (int unsigned k = 0; k < NUM_STG; k++) begin
      if (!hit && stgWe[k] && (stgRd[k*REG_AW +: REG_AW] != '0) &&
          (stgRd[k*REG_AW +: REG_AW] == src)) begin
        sel = SEL_W'(k + 1);
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/forward_hazard_unit.sv
// Operand forwarding selects, load-use stall/bubble generation and
// saturating statistics counters for the EX stage.
module forward_hazard_unit
  import hazard_pkg::*;
#(
  parameter  int unsigned REG_AW   = 5,
  parameter  int unsigned NUM_SRC  = 2,
  parameter  int unsigned NUM_STG  = 2,
  parameter  int unsigned LOAD_LAT = 1,
  parameter  int unsigned CNT_W    = 16,
  localparam int unsigned SEL_W    = $clog2(NUM_STG + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_SRC*REG_AW-1:0]   ex_src_i,
  input  logic [NUM_SRC*REG_AW-1:0]   id_src_i,
  input  logic [NUM_SRC-1:0]          id_src_use_i,
  input  logic [NUM_STG*REG_AW-1:0]   stg_rd_i,
  input  logic [NUM_STG-1:0]          stg_we_i,
  input  logic [REG_AW-1:0]           ex_rd_i,
  input  logic                        ex_memread_i,
  input  logic                        clr_cnt_i,
  output logic [NUM_SRC*SEL_W-1:0]    fwd_sel_o,
  output logic                        stall_o,
  output logic                        bubble_o,
  output logic [CNT_W-1:0]            stall_cnt_o,
  output logic [CNT_W-1:0]            fwd_cnt_o
);

  // The first stall cycle is spent in IDLE, the last one with rem == 0.
  localparam logic [REM_W-1:0] REM_INIT = (LOAD_LAT > 1) ? REM_W'(LOAD_LAT - 2) : '0;

  hazState_t          state;
  logic [REM_W-1:0]   rem;
  logic [NUM_SRC*SEL_W-1:0] matchSel;
  logic               loadUse;
  logic               anyFwd;

  for (genvar j = 0; j < NUM_SRC; j++) begin : gMatch
    fwd_src_match #(
      .REG_AW (REG_AW),
      .NUM_STG(NUM_STG),
      .SEL_W  (SEL_W)
    ) uMatch (
      .src  (ex_src_i[j*REG_AW +: REG_AW]),
      .stgRd(stg_rd_i),
      .stgWe(stg_we_i),
      .sel  (matchSel[j*SEL_W +: SEL_W])
    );
  end

  // Load in EX whose destination is read by the instruction in ID.
  always_comb begin
    loadUse = 1'b0;
    for (int unsigned j = 0; j < NUM_SRC; j++) begin
      if (id_src_use_i[j] && (id_src_i[j*REG_AW +: REG_AW] == ex_rd_i)) begin
        loadUse = 1'b1;
      end
    end
    loadUse = loadUse && ex_memread_i && (ex_rd_i != '0);
  end

  // Outputs are Mealy in IDLE and forced low while reset is held.
  always_comb begin
    fwd_sel_o = rst_i ? '0 : matchSel;
    stall_o   = !rst_i && ((state == STALL) || loadUse);
    bubble_o  = stall_o;
    anyFwd    = |fwd_sel_o;
  end

  // Stall sequencer: IDLE covers the first stall cycle, STALL the rest.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      rem   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (loadUse && (LOAD_LAT > 1)) begin
            state <= STALL;
            rem   <= REM_INIT;
          end
        end
        STALL: begin
          if (rem == '0) begin
            state <= IDLE;
          end else begin
            rem <= rem - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Saturating statistics; clear wins over a same-cycle increment.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      fwd_cnt_o   <= '0;
    end else if (clr_cnt_i) begin
      stall_cnt_o <= '0;
      fwd_cnt_o   <= '0;
    end else begin
      if (stall_o && (stall_cnt_o != '1)) begin
        stall_cnt_o <= stall_cnt_o + 1'b1;
      end
      if (anyFwd && (fwd_cnt_o != '1)) begin
        fwd_cnt_o <= fwd_cnt_o + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed bench for forward_hazard_unit across three parameterisations.
module tb_forward_hazard_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // Default parameters
  logic [9:0]  dExSrc, dIdSrc, dStgRd;
  logic [1:0]  dIdUse, dStgWe;
  logic [4:0]  dExRd;
  logic        dExMr, dClr, dStall, dBubble;
  logic [3:0]  dFwdSel;
  logic [15:0] dStallCnt, dFwdCnt;

  // LOAD_LAT=3, CNT_W=4
  logic [9:0]  lExSrc, lIdSrc, lStgRd;
  logic [1:0]  lIdUse, lStgWe;
  logic [4:0]  lExRd;
  logic        lExMr, lClr, lStall, lBubble;
  logic [3:0]  lFwdSel;
  logic [3:0]  lStallCnt, lFwdCnt;

  // NUM_SRC=3, NUM_STG=3
  logic [14:0] wExSrc, wIdSrc, wStgRd;
  logic [2:0]  wIdUse, wStgWe;
  logic [4:0]  wExRd;
  logic        wExMr, wClr, wStall, wBubble;
  logic [5:0]  wFwdSel;
  logic [15:0] wStallCnt, wFwdCnt;

  forward_hazard_unit uDef (
    .clk_i(clk), .rst_i(rst), .ex_src_i(dExSrc), .id_src_i(dIdSrc),
    .id_src_use_i(dIdUse), .stg_rd_i(dStgRd), .stg_we_i(dStgWe),
    .ex_rd_i(dExRd), .ex_memread_i(dExMr), .clr_cnt_i(dClr),
    .fwd_sel_o(dFwdSel), .stall_o(dStall), .bubble_o(dBubble),
    .stall_cnt_o(dStallCnt), .fwd_cnt_o(dFwdCnt)
  );

  forward_hazard_unit #(.LOAD_LAT(3), .CNT_W(4)) uLat (
    .clk_i(clk), .rst_i(rst), .ex_src_i(lExSrc), .id_src_i(lIdSrc),
    .id_src_use_i(lIdUse), .stg_rd_i(lStgRd), .stg_we_i(lStgWe),
    .ex_rd_i(lExRd), .ex_memread_i(lExMr), .clr_cnt_i(lClr),
    .fwd_sel_o(lFwdSel), .stall_o(lStall), .bubble_o(lBubble),
    .stall_cnt_o(lStallCnt), .fwd_cnt_o(lFwdCnt)
  );

  forward_hazard_unit #(.NUM_SRC(3), .NUM_STG(3)) uWide (
    .clk_i(clk), .rst_i(rst), .ex_src_i(wExSrc), .id_src_i(wIdSrc),
    .id_src_use_i(wIdUse), .stg_rd_i(wStgRd), .stg_we_i(wStgWe),
    .ex_rd_i(wExRd), .ex_memread_i(wExMr), .clr_cnt_i(wClr),
    .fwd_sel_o(wFwdSel), .stall_o(wStall), .bubble_o(wBubble),
    .stall_cnt_o(wStallCnt), .fwd_cnt_o(wFwdCnt)
  );

  task automatic clearInputs;
    dExSrc = '0; dIdSrc = '0; dStgRd = '0; dIdUse = '0; dStgWe = '0; dExRd = '0; dExMr = 0; dClr = 0;
    lExSrc = '0; lIdSrc = '0; lStgRd = '0; lIdUse = '0; lStgWe = '0; lExRd = '0; lExMr = 0; lClr = 0;
    wExSrc = '0; wIdSrc = '0; wStgRd = '0; wIdUse = '0; wStgWe = '0; wExRd = '0; wExMr = 0; wClr = 0;
  endtask

  task automatic applyReset;
    @(negedge clk);
    rst = 1'b1;
    clearInputs();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    dStgWe = 2'b11; dStgRd = {5'd5, 5'd5}; dExSrc = {5'd5, 5'd5};
    dExMr = 1'b1; dExRd = 5'd8; dIdSrc = {5'd8, 5'd8}; dIdUse = 2'b11;
    lExMr = 1'b1; lExRd = 5'd8; lIdSrc = {5'd0, 5'd8}; lIdUse = 2'b01;
    #1;
    checks++; if (dFwdSel !== 4'b0) begin failures++; $display("FAIL reset_fwdsel got=%b exp=0000", dFwdSel); end
    checks++; if (dStall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", dStall); end
    checks++; if (dBubble !== 1'b0) begin failures++; $display("FAIL reset_bubble got=%b exp=0", dBubble); end
    checks++; if (lStall !== 1'b0) begin failures++; $display("FAIL reset_lat_stall got=%b exp=0", lStall); end
    checks++; if (dStallCnt !== 16'd0 || dFwdCnt !== 16'd0) begin
      failures++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", dStallCnt, dFwdCnt);
    end
    @(posedge clk); #1;
    checks++; if (lStall !== 1'b0 || lStallCnt !== 4'd0) begin
      failures++; $display("FAIL reset_held got stall=%b cnt=%0d exp 0/0", lStall, lStallCnt);
    end
    clearInputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_forward_priority;
    logic [1:0] we  [6] = '{2'b11, 2'b10, 2'b11, 2'b01, 2'b11, 2'b00};
    logic [9:0] rd  [6] = '{{5'd5,5'd5}, {5'd5,5'd5}, {5'd9,5'd5}, {5'd9,5'd5}, {5'd3,5'd3}, {5'd4,5'd4}};
    logic [9:0] src [6] = '{{5'd7,5'd5}, {5'd7,5'd5}, {5'd9,5'd5}, {5'd9,5'd5}, {5'd3,5'd4}, {5'd4,5'd4}};
    logic [3:0] exp [6] = '{4'b0001, 4'b0010, 4'b1001, 4'b0001, 4'b0100, 4'b0000};
    int unsigned expCnt = 0;
    applyReset();
    for (int unsigned i = 0; i < 6; i++) begin
      @(negedge clk);
      dStgWe = we[i]; dStgRd = rd[i]; dExSrc = src[i];
      #1;
      checks++; if (dFwdSel !== exp[i]) begin
        failures++; $display("FAIL fwd_priority[%0d] got=%b exp=%b", i, dFwdSel, exp[i]);
      end
      if (exp[i] != 4'b0) expCnt++;
      @(posedge clk);
    end
    #1;
    checks++; if (dFwdCnt !== 16'(expCnt)) begin
      failures++; $display("FAIL fwd_cnt_default got=%0d exp=%0d", dFwdCnt, expCnt);
    end
    clearInputs();
  endtask

  task automatic test_reg_zero;
    applyReset();
    @(negedge clk);
    dStgWe = 2'b11; dStgRd = {5'd0, 5'd0}; dExSrc = {5'd0, 5'd0};
    #1;
    checks++; if (dFwdSel !== 4'b0) begin failures++; $display("FAIL reg_zero got=%b exp=0000", dFwdSel); end
    @(posedge clk);
    @(negedge clk);
    dStgWe = 2'b01; dStgRd = {5'd7, 5'd0}; dExSrc = {5'd0, 5'd0};
    #1;
    checks++; if (dFwdSel !== 4'b0) begin failures++; $display("FAIL reg_zero_b got=%b exp=0000", dFwdSel); end
    @(posedge clk); #1;
    checks++; if (dFwdCnt !== 16'd0) begin failures++; $display("FAIL reg_zero_cnt got=%0d exp=0", dFwdCnt); end
    clearInputs();
  endtask

  task automatic test_load_use_lat1;
    logic       mr  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [4:0] erd [6] = '{5'd8, 5'd8, 5'd8, 5'd8, 5'd0, 5'd8};
    logic [9:0] isrc[6] = '{{5'd0,5'd8}, {5'd8,5'd0}, {5'd8,5'd8}, {5'd0,5'd8}, {5'd0,5'd0}, {5'd3,5'd4}};
    logic [1:0] use_[6] = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b11, 2'b11};
    logic       exp [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    applyReset();
    for (int unsigned i = 0; i < 6; i++) begin
      @(negedge clk);
      dExMr = mr[i]; dExRd = erd[i]; dIdSrc = isrc[i]; dIdUse = use_[i];
      #1;
      checks++; if (dStall !== exp[i] || dBubble !== exp[i]) begin
        failures++; $display("FAIL load_use_lat1[%0d] got stall=%b bubble=%b exp=%b", i, dStall, dBubble, exp[i]);
      end
      @(posedge clk);
    end
    #1;
    checks++; if (dStallCnt !== 16'd2) begin failures++; $display("FAIL stall_cnt_lat1 got=%0d exp=2", dStallCnt); end
    clearInputs();
  endtask

  task automatic test_load_stall_lat3;
    logic exp [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    applyReset();
    for (int unsigned i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) begin
        lExMr = 1'b1; lExRd = 5'd8; lIdSrc = {5'd0, 5'd8}; lIdUse = 2'b01;
      end else begin
        lExMr = 1'b0; lExRd = '0; lIdSrc = '0; lIdUse = '0;
      end
      if (i == 1) begin
        lStgWe = 2'b01; lStgRd = {5'd0, 5'd3}; lExSrc = {5'd0, 5'd3};
      end else begin
        lStgWe = '0; lStgRd = '0; lExSrc = '0;
      end
      #1;
      checks++; if (lStall !== exp[i] || lBubble !== exp[i]) begin
        failures++; $display("FAIL lat3_stall[%0d] got stall=%b bubble=%b exp=%b", i, lStall, lBubble, exp[i]);
      end
      if (i == 1) begin
        checks++; if (lFwdSel !== 4'b0001) begin failures++; $display("FAIL fwd_during_stall got=%b exp=0001", lFwdSel); end
      end
      @(posedge clk);
    end
    #1;
    checks++; if (lStallCnt !== 4'd3) begin failures++; $display("FAIL lat3_stall_cnt got=%0d exp=3", lStallCnt); end
    checks++; if (lFwdCnt !== 4'd1) begin failures++; $display("FAIL lat3_fwd_cnt got=%0d exp=1", lFwdCnt); end
    clearInputs();
  endtask

  task automatic test_reset_mid_stall;
    applyReset();
    @(negedge clk);
    lExMr = 1'b1; lExRd = 5'd8; lIdSrc = {5'd0, 5'd8}; lIdUse = 2'b01;
    @(posedge clk);
    @(negedge clk);
    clearInputs();
    #1;
    checks++; if (lStall !== 1'b1) begin failures++; $display("FAIL mid_stall_pre got=%b exp=1", lStall); end
    rst = 1'b1;
    #1;
    checks++; if (lStall !== 1'b0 || lBubble !== 1'b0) begin
      failures++; $display("FAIL mid_stall_async got stall=%b bubble=%b exp=0/0", lStall, lBubble);
    end
    checks++; if (lStallCnt !== 4'd0) begin failures++; $display("FAIL mid_stall_cnt got=%0d exp=0", lStallCnt); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (lStall !== 1'b0) begin failures++; $display("FAIL mid_stall_release got=%b exp=0", lStall); end
    @(posedge clk); #1;
    checks++; if (lStall !== 1'b0 || lStallCnt !== 4'd0) begin
      failures++; $display("FAIL mid_stall_idle got stall=%b cnt=%0d exp 0/0", lStall, lStallCnt);
    end
  endtask

  task automatic test_saturate_clear;
    logic [3:0] expCnt;
    applyReset();
    @(negedge clk);
    lStgWe = 2'b01; lStgRd = {5'd0, 5'd3}; lExSrc = {5'd0, 5'd3};
    lExMr = 1'b1; lExRd = 5'd8; lIdSrc = {5'd0, 5'd8}; lIdUse = 2'b01;
    for (int unsigned i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      expCnt = (i > 15) ? 4'd15 : 4'(i);
      if (i == 10 || i == 15 || i == 16 || i == 20) begin
        checks++; if (lFwdCnt !== expCnt) begin failures++; $display("FAIL fwd_sat[%0d] got=%0d exp=%0d", i, lFwdCnt, expCnt); end
        checks++; if (lStallCnt !== expCnt) begin failures++; $display("FAIL stall_sat[%0d] got=%0d exp=%0d", i, lStallCnt, expCnt); end
      end
    end
    @(negedge clk);
    lClr = 1'b1;
    @(posedge clk); #1;
    checks++; if (lFwdCnt !== 4'd0 || lStallCnt !== 4'd0) begin
      failures++; $display("FAIL clr_priority got=%0d/%0d exp=0/0", lFwdCnt, lStallCnt);
    end
    @(negedge clk);
    lClr = 1'b0;
    @(posedge clk); #1;
    checks++; if (lFwdCnt !== 4'd1 || lStallCnt !== 4'd1) begin
      failures++; $display("FAIL clr_resume got=%0d/%0d exp=1/1", lFwdCnt, lStallCnt);
    end
    clearInputs();
  endtask

  task automatic test_wide;
    logic [2:0]  we  [4] = '{3'b100, 3'b110, 3'b111, 3'b011};
    logic [14:0] rd  [4] = '{{5'd6,5'd0,5'd0}, {5'd6,5'd6,5'd0}, {5'd6,5'd6,5'd6}, {5'd6,5'd6,5'd6}};
    logic [14:0] src [4] = '{{5'd6,5'd1,5'd2}, {5'd6,5'd1,5'd2}, {5'd6,5'd6,5'd6}, {5'd0,5'd7,5'd6}};
    logic [5:0]  exp [4] = '{6'b11_00_00, 6'b10_00_00, 6'b01_01_01, 6'b00_00_01};
    applyReset();
    for (int unsigned i = 0; i < 4; i++) begin
      @(negedge clk);
      wStgWe = we[i]; wStgRd = rd[i]; wExSrc = src[i];
      #1;
      checks++; if (wFwdSel !== exp[i]) begin
        failures++; $display("FAIL wide_fwd[%0d] got=%b exp=%b", i, wFwdSel, exp[i]);
      end
      @(posedge clk);
    end
    @(negedge clk);
    wStgWe = '0; wStgRd = '0; wExSrc = '0;
    wExMr = 1'b1; wExRd = 5'd9; wIdSrc = {5'd9, 5'd0, 5'd0}; wIdUse = 3'b100;
    #1;
    checks++; if (wStall !== 1'b1) begin failures++; $display("FAIL wide_load_use got=%b exp=1", wStall); end
    @(posedge clk);
    @(negedge clk);
    wIdUse = 3'b011;
    #1;
    checks++; if (wStall !== 1'b0) begin failures++; $display("FAIL wide_no_use got=%b exp=0", wStall); end
    @(posedge clk); #1;
    checks++; if (wFwdCnt !== 16'd4 || wStallCnt !== 16'd1) begin
      failures++; $display("FAIL wide_counters got=%0d/%0d exp=4/1", wFwdCnt, wStallCnt);
    end
    clearInputs();
  endtask

  initial begin
    clearInputs();
    test_reset();
    test_forward_priority();
    test_reg_zero();
    test_load_use_lat1();
    test_load_stall_lat3();
    test_reset_mid_stall();
    test_saturate_clear();
    test_wide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
